// File: rtl/product_bin2bcd.sv
// Sequential double-dabble converter: one product bit per clock into packed BCD digits,
// with valid/ready on both sides and the result held until the consumer takes it.
module product_bin2bcd #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  busy
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      bin_q, bin_d;
   logic [4*DIGITS-1:0]   scratch_q, scratch_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [4*DIGITS-1:0]   adj;
   logic [4*DIGITS-1:0]   shifted;

   // Add-3 on every digit >= 5 before the shift, so the doubled digit carries correctly.
   always_comb begin
      adj = scratch_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
   end

   assign shifted = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      scratch_d = scratch_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               bin_d     = bin;
               scratch_d = '0;
               cnt_d     = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            bin_d     = {bin_q[WIDTH-2:0], 1'b0};
            scratch_d = shifted;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               bcd_d   = shifted;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         scratch_q <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         scratch_q <= scratch_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !reset;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == SHIFT);
   assign bcd       = bcd_q;

endmodule

// File: doc/product_bin2bcd.md
# product_bin2bcd

Sequential binary-to-BCD converter sitting directly downstream of the 4-bit unsigned multiplier. It accepts the 8-bit product `z` through a valid/ready handshake and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It returns three packed BCD digits for the board's seven-segment display driver. One conversion is in flight at a time; the result is held until the consumer takes it.

## Interface
- `WIDTH`, 8: binary input width; the product width of the upstream multiplier.
- `DIGITS`, 3: BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `bin` holds a product to convert.
- `in_ready`  out  1  block can accept; `(state==IDLE) & ~reset`.
- `bin`  in  WIDTH  unsigned product (multiplier `z`).
- `out_valid`  out  1  `bcd` holds a completed conversion.
- `out_ready`  in  1  consumer takes `bcd` this cycle.
- `bcd`  out  4*DIGITS  packed BCD: [3:0] ones, [7:4] tens, [11:8] hundreds.
- `busy`  out  1  high in SHIFT state.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready` at an edge: load `bin` into the binary shift register, clear the BCD scratch register, clear the bit counter, then go to SHIFT.
- SHIFT, one step per cycle:
  - Each scratch digit >= 5 gets +3; the adjustment is combinational on the current digits.
  - Then shift {scratch, binreg} left by 1, with the binreg MSB entering the scratch LSB.
  - Counter increments each step.
  - On the step where counter == WIDTH-1: write the final shifted scratch value into the `bcd` output register and go to DONE.
- DONE:
  - `out_valid`=1 and `bcd` stable.
  - On `out_ready`, go to IDLE.
  - `in_valid` is ignored; no acceptance outside IDLE.
- `bcd` output register changes only at conversion completion or reset. After handshake it keeps the last result while `out_valid`=0.
- Counter width is clog2(WIDTH)+1. The add-3 check is done per 4-bit digit, unsigned, and never overflows a digit for legal parameters.
- Every digit of a completed `bcd` is in the range 0..9.

## Timing
- Reset values: state=IDLE, `out_valid`=0, `busy`=0, `bcd`=0, scratch, binreg and counter=0, `in_ready`=0 while `reset` is high.
- Latency: input accepted at edge E0. SHIFT occupies edges E1..E8 (WIDTH edges). `out_valid` rises after E8, i.e. WIDTH cycles after acceptance.
- `busy` is high from after E0 through E8.
- `out_valid` stays high and `bcd` is held for any length of `out_ready`=0 back-pressure.
- If `out_ready` is already high when `out_valid` rises: handshake at the next edge (E9), IDLE after E9, `in_ready`=1 in cycle E9+1.
- Minimum spacing between accepted inputs: WIDTH+2 cycles.
- Reset mid-operation (SHIFT or DONE):
  - At the reset edge: IDLE, `bcd`=0, `out_valid`=0, and the in-flight conversion is discarded.
  - `in_ready` returns the first cycle after `reset` falls.
- `in_valid` together with `reset`: reset wins, and the input is not accepted.
- `out_ready` in IDLE or SHIFT: no effect.

## Test plan
- Input 3×1: `bin`=8'h03 accepted -> `out_valid` rises exactly 8 cycles later with `bcd`=12'h003; `busy` is high for exactly those 8 cycles.
- Input 4×4=16 and 2×8=16: `bin`=8'h10 -> `bcd`=12'h016. Input 0×0: `bin`=8'h00 -> `bcd`=12'h000.
- Input 15×1 and 15×15:
  - `bin`=8'h0F -> `bcd`=12'h015.
  - `bin`=8'hE1 (225) -> `bcd`=12'h225.
  - `bin`=8'hFF -> `bcd`=12'h255.
  - Exhaustive sweep 0..255 against a reference model: every digit is <= 9.
- Back-pressure: hold `out_ready`=0 for 5 cycles after `out_valid` -> `bcd` and `out_valid` stay constant. `in_valid`=1 with `bin`=8'h07 during this window is not accepted (`in_ready`=0). Raise `out_ready` -> IDLE next cycle, then 8'h07 is accepted -> 12'h007.
- Back-to-back with `out_ready` tied high: inputs 8'h03, 8'h10, 8'h00, 8'h10, 8'h0F -> results 003, 016, 000, 016, 015 in order, each separated by 10 cycles.
- Reset mid-SHIFT: assert `reset` 4 cycles after accepting 8'hFF -> next cycle state is IDLE, `busy`=0, `out_valid`=0, `bcd`=0. After release, 8'h05 converts to 12'h005.
